demux_tdm_1to8: RTL and testbench
=================================

// Module: demux_tdm_1to8
//
// PURPOSE
//   Receive end of the 8:1 channel multiplexer. A single lane carries one sample
//   per slot in round-robin order 0..7. The slot order matches the mux select
//   code {s2,s1,s0}. This block demultiplexes the lane back into 8 registered
//   channel outputs and publishes each complete frame atomically.
//   It sits downstream of the sequential mux scanner, across the shared lane.
//
// PARAMETERS
//   CHANNELS  8  number of slots per frame; power of two, >=2
//   SEL_W     3  slot index width, = log2(CHANNELS)
//   WIDTH     1  bits per channel sample
//
// PORTS
//   clk          in   1               single clock; all logic on posedge
//   rst          in   1               synchronous, active-high reset
//   din          in   WIDTH           lane sample
//   din_valid    in   1               din carries a sample this cycle
//   frame_start  in   1               qualifies din as slot 0; ignored unless din_valid=1
//   dout         out  CHANNELS*WIDTH  slot k at dout[k*WIDTH +: WIDTH]; last complete frame
//   frame_valid  out  1               1-cycle pulse: dout just updated
//   slot         out  SEL_W           index the next accepted sample will be written to
//   sync_err     out  1               1-cycle pulse: framing violation detected
//
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE, slot=0, shadow regs=0, dout=0,
//     frame_valid=0, sync_err=0. Reset mid-frame discards the partial frame
//     and clears dout.
//   Accept = din_valid=1. Nothing changes on cycles with din_valid=0; slot and
//     shadow hold, and pulse outputs return to 0.
//   IDLE:
//     - accept with frame_start=1: shadow[0]<=din, slot<=1, go to RUN.
//     - accept with frame_start=0: sample dropped; no error; stay in IDLE.
//   RUN:
//     - accept at slot=s, 0<s<CHANNELS-1, frame_start=0:
//       shadow[s]<=din, slot<=s+1.
//     - accept at slot=CHANNELS-1, frame_start=0:
//       dout<=shadow[0..CHANNELS-2] plus din in the top slot.
//       frame_valid=1 on the next cycle. slot<=0 (wraps). Stay in RUN.
//     - accept at slot=0 with frame_start=1: shadow[0]<=din, slot<=1 (back-to-back frames).
//     - accept at slot=0 with frame_start=0: sync_err=1 next cycle, sample dropped,
//       slot<=0, go to IDLE.
//     - accept at slot!=0 with frame_start=1 (early restart): sync_err=1 next cycle.
//       Partial frame discarded; dout NOT updated. shadow[0]<=din, slot<=1, stay in RUN.
//   Latency: the last slot is accepted at cycle N; dout and frame_valid are visible
//     after the edge ending cycle N (1 cycle, registered).
//   dout holds its value until the next complete frame; there is no partial update.
//   frame_valid and sync_err are never asserted in the same cycle.
//   Shadow regs for discarded partial frames may hold stale data. They are not
//     observable, because every slot is rewritten before the next publish.
//
// TESTING
//   1 Reset, then 8 accepts with frame_start on the first, din=1,0,1,1,0,0,1,0
//     -> the next cycle has dout=8'b0100_1101 and frame_valid=1 for exactly one cycle.
//   2 Same frame with din_valid=0 gaps inserted between slots 2/3 and 6/7
//     -> identical dout; slot holds during the gaps; frame_valid fires once.
//   3 Two back-to-back frames, 16 consecutive accepts (0xA5 then 0x3C, LSB=slot0)
//     -> dout=0xA5 then 0x3C, with frame_valid pulses 8 cycles apart.
//   4 frame_start asserted at slot 5 mid-frame
//     -> sync_err pulse, dout unchanged, slot=1. The following 7 slots complete a
//        frame and publish.
//   5 Accept at slot 0 without frame_start while in RUN
//     -> sync_err pulse, state IDLE. Accepts without frame_start are ignored until
//        frame_start is seen.
//   6 rst asserted at slot 4 after a published frame 0xFF
//     -> dout=0, slot=0, no pulses; the next full frame publishes normally.

Source files
------------

// File: rtl/demux_tdm_1to8.sv
// Receive end of the TDM lane: collects one sample per slot into shadow registers
// and publishes each complete frame to dout in a single cycle.
module demux_tdm_1to8 #(
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int WIDTH    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          din,
  input  logic                      din_valid,
  input  logic                      frame_start,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic                      frame_valid,
  output logic [SEL_W-1:0]          slot,
  output logic                      sync_err
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [SEL_W-1:0] LastSlot = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W-1:0] OneSlot  = SEL_W'(1);

  state_t                                state_q;
  logic [SEL_W-1:0]                      slot_q;
  // The top slot is never shadowed: it goes straight from din into dout.
  logic [CHANNELS-2:0][WIDTH-1:0]        shadow_q;
  logic [CHANNELS-1:0][WIDTH-1:0]        dout_q;
  logic                                  frameValid_q;
  logic                                  syncErr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      shadow_q     <= '0;
      dout_q       <= '0;
      frameValid_q <= 1'b0;
      syncErr_q    <= 1'b0;
    end else begin
      frameValid_q <= 1'b0;
      syncErr_q    <= 1'b0;
      if (din_valid) begin
        unique case (state_q)
          IDLE: begin
            if (frame_start) begin
              shadow_q[0] <= din;
              slot_q      <= OneSlot;
              state_q     <= RUN;
            end
          end
          RUN: begin
            if (frame_start) begin
              // A restart anywhere but slot 0 abandons the partial frame.
              if (slot_q != '0) begin
                syncErr_q <= 1'b1;
              end
              shadow_q[0] <= din;
              slot_q      <= OneSlot;
            end else if (slot_q == '0) begin
              syncErr_q <= 1'b1;
              slot_q    <= '0;
              state_q   <= IDLE;
            end else if (slot_q == LastSlot) begin
              dout_q       <= {din, shadow_q};
              frameValid_q <= 1'b1;
              slot_q       <= '0;
            end else begin
              shadow_q[slot_q] <= din;
              slot_q           <= slot_q + OneSlot;
            end
          end
          default: begin
            state_q <= IDLE;
            slot_q  <= '0;
          end
        endcase
      end
    end
  end

  assign dout        = dout_q;
  assign frame_valid = frameValid_q;
  assign slot        = slot_q;
  assign sync_err    = syncErr_q;

endmodule

// File: tb/tb_demux_tdm_1to8.sv
// Scoreboard bench for demux_tdm_1to8: stimulus pushes hand-computed expected
// pulses, a monitor pops and compares them whenever frame_valid or sync_err fires.
module tb_demux_tdm_1to8;

  typedef struct {
    bit         isFrame;
    logic [7:0] dout;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [0:0] din;
  logic       din_valid;
  logic       frame_start;
  logic [7:0] dout;
  logic       frame_valid;
  logic [2:0] slot;
  logic       sync_err;

  exp_t expQ[$];
  int   checks = 0;
  int   passes = 0;
  int   cycle = 0;
  int   lastFrameCycle = 0;
  int   frameGap = 0;

  demux_tdm_1to8 #(.CHANNELS(8), .SEL_W(3), .WIDTH(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_start(frame_start),
    .dout       (dout),
    .frame_valid(frame_valid),
    .slot       (slot),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic applyStimulus(input logic v, input logic d, input logic fs);
    @(negedge clk);
    din_valid   = v;
    din         = d;
    frame_start = fs;
  endtask

  task automatic pushFrame(input logic [7:0] v);
    exp_t e;
    e.isFrame = 1'b1;
    e.dout    = v;
    expQ.push_back(e);
  endtask

  task automatic pushErr(input logic [7:0] heldDout);
    exp_t e;
    e.isFrame = 1'b0;
    e.dout    = heldDout;
    expQ.push_back(e);
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #1;
  endtask

  // Full frame of 8 consecutive accepts, frame_start on slot 0.
  task automatic sendByte(input logic [7:0] v);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) pushFrame(v);
      applyStimulus(1'b1, v[k], k == 0);
    end
  endtask

  // Monitor: every pulse must match the head of the expectation queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (frame_valid || sync_err) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_pulse", {30'b0, frame_valid, sync_err}, 32'h0);
        end else begin
          e = expQ.pop_front();
          checkOutput(e.isFrame ? "frame_pulse" : "sync_err_pulse",
                      {30'b0, frame_valid, sync_err}, e.isFrame ? 32'h2 : 32'h1);
          checkOutput("dout_at_pulse", {24'b0, dout}, {24'b0, e.dout});
        end
        if (frame_valid) begin
          frameGap       = cycle - lastFrameCycle;
          lastFrameCycle = cycle;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] pat;
    rst = 1'b1; din = '0; din_valid = 1'b0; frame_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_dout", {24'b0, dout}, 32'h0);
    checkOutput("reset_slot", {29'b0, slot}, 32'h0);
    checkOutput("reset_pulses", {30'b0, frame_valid, sync_err}, 32'h0);

    $display("[TB] test 1: single frame 0x4D");
    sendByte(8'h4D);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t1_slot_wrap", {29'b0, slot}, 32'h0);

    $display("[TB] test 2: same frame with gaps");
    pat = 8'h4D;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) pushFrame(pat);
      applyStimulus(1'b1, pat[k], k == 0);
      if (k == 2 || k == 6) begin
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        afterEdge();
        checkOutput("t2_slot_hold", {29'b0, slot}, k + 1);
        checkOutput("t2_dout_hold", {24'b0, dout}, 32'h4D);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] test 3: back-to-back frames");
    sendByte(8'hA5);
    sendByte(8'h3C);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t3_frame_gap", frameGap, 32'd8);

    $display("[TB] test 4: early restart at slot 5");
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b1, k == 0);
    pushErr(8'h3C);
    applyStimulus(1'b1, 1'b0, 1'b1);
    afterEdge();
    checkOutput("t4_slot_after_restart", {29'b0, slot}, 32'h1);
    checkOutput("t4_dout_unchanged", {24'b0, dout}, 32'h3C);
    pat = 8'h96;
    for (int k = 1; k < 8; k++) begin
      if (k == 7) pushFrame(pat);
      applyStimulus(1'b1, pat[k], 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] test 5: missing frame_start at slot 0");
    pushErr(8'h96);
    applyStimulus(1'b1, 1'b1, 1'b0);
    afterEdge();
    checkOutput("t5_slot_idle", {29'b0, slot}, 32'h0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t5_slot_ignored", {29'b0, slot}, 32'h0);
    checkOutput("t5_dout_held", {24'b0, dout}, 32'h96);
    sendByte(8'h5A);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] test 6: reset mid-frame");
    sendByte(8'hFF);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, k == 0);
    afterEdge();
    checkOutput("t6_slot_before_rst", {29'b0, slot}, 32'h4);
    checkOutput("t6_dout_before_rst", {24'b0, dout}, 32'hFF);
    @(negedge clk);
    rst = 1'b1; din_valid = 1'b0; frame_start = 1'b0;
    afterEdge();
    checkOutput("t6_dout_cleared", {24'b0, dout}, 32'h0);
    checkOutput("t6_slot_cleared", {29'b0, slot}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    sendByte(8'h81);
    applyStimulus(1'b0, 1'b0, 1'b0);

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("queue_drained", expQ.size(), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
